// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed leaky integrate-and-fire sequencer: one update datapath is
// shared across all neurons, swept in index order on every timestep strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for tick; busy low
// CALC   | update neuron idx (leak, integrate, threshold, refractory)
// EMIT   | present spike for neuron idx until spike_ready
// DONE   | one-cycle done pulse, then back to IDLE
module lif_sweep_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int ADDR_W     = 2,
  parameter int REF_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic [ADDR_W-1:0] cur_addr,
  input  logic [WIDTH-1:0]  cur_in,
  input  logic [WIDTH-1:0]  threshold,
  input  logic [REF_W-1:0]  refrac_len,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  input  logic              spike_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              overrun_q;

  logic [WIDTH-1:0]  v_q [N_NEURONS];
  logic [REF_W-1:0]  r_q [N_NEURONS];

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  v_sat;
  logic              refrac_active;
  logic              fire;
  logic              last;

  // Leak never exceeds v, so only the upper end needs saturating.
  always_comb begin
    sum   = {1'b0, v_q[idx]} - {1'b0, (v_q[idx] >> LEAK_SHIFT)} + {1'b0, cur_in};
    v_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  assign refrac_active = (r_q[idx] != '0);
  assign fire          = !refrac_active && (v_sat >= threshold);
  assign last          = (idx == ADDR_W'(N_NEURONS - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (tick) begin
          idx_nxt   = '0;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (fire) begin
          state_nxt = S_EMIT;
        end else if (last) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      S_EMIT: begin
        if (spike_ready) begin
          if (last) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = S_CALC;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else if (state == S_CALC) begin
      if (refrac_active) begin
        r_q[idx] <= r_q[idx] - REF_W'(1);
        v_q[idx] <= '0;
      end else if (fire) begin
        v_q[idx] <= '0;
        r_q[idx] <= refrac_len;
      end else begin
        v_q[idx] <= v_sat;
      end
    end
  end

  // Sticky until reset; a tick during DONE also counts as missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (tick && (state != S_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign cur_addr    = idx;
  assign spike_id    = idx;
  assign spike_valid = (state == S_EMIT);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Directed bench for lif_sweep_scheduler: reset, integration, backpressure,
// refractory, saturation, overrun and reset during a pending spike.
module tb_lif_sweep_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] cur_addr;
  logic [7:0] cur_in = 8'd20;
  logic [7:0] threshold = 8'd100;
  logic [2:0] refrac_len = 3'd0;
  logic       spike_valid;
  logic [1:0] spike_id;
  logic       spike_ready = 1'b1;
  logic       busy;
  logic       done;
  logic       overrun;

  int vectors = 0;
  int errors  = 0;

  lif_sweep_scheduler #(
    .N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(3), .ADDR_W(2), .REF_W(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .cur_addr(cur_addr), .cur_in(cur_in),
    .threshold(threshold), .refrac_len(refrac_len), .spike_valid(spike_valid),
    .spike_id(spike_id), .spike_ready(spike_ready), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Pulses tick, then tracks the sweep; dcyc is done's cycle offset from tick.
  task automatic sweep(input int stall, input int tick_at,
                       output int dcyc, output int nspk, output logic [15:0] ids);
    int  c;
    int  left;
    bit  got;
    left = stall; nspk = 0; ids = '0; dcyc = 0; got = 0;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    c = 1;
    while (!got && c < 100) begin
      @(negedge clk);
      if (spike_valid && left > 0) begin
        spike_ready = 1'b0;
        left--;
        chk("stall_id", 32'(spike_id), 0);
        chk("stall_busy", 32'(busy), 1);
      end else begin
        spike_ready = 1'b1;
      end
      if (spike_valid && spike_ready) begin
        if (nspk < 4) ids[nspk*4 +: 4] = 4'(spike_id);
        nspk++;
      end
      if (done) begin
        got  = 1;
        dcyc = c;
      end else begin
        chk("busy_in_sweep", 32'(busy), 1);
      end
      @(posedge clk); #1;
      c++;
      tick = (c == tick_at);
    end
    tick = 1'b0;
    spike_ready = 1'b1;
    if (!got) chk("sweep_timeout", 0, 1);
  endtask

  int          dc, ns;
  logic [15:0] id;
  int          exp_v [6] = '{38, 54, 68, 80, 90, 99};

  initial begin
    // Reset
    do_reset();
    chk("rst_valid", 32'(spike_valid), 0);
    chk("rst_id", 32'(spike_id), 0);
    chk("rst_addr", 32'(cur_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Integration: 20, 38, ..., 99, then spike on sweep 8
    sweep(0, 0, dc, ns, id);
    chk("s1_done_cyc", 32'(dc), 5);
    chk("s1_nspk", 32'(ns), 0);
    chk("s1_v0", 32'(dut.v_q[0]), 20);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    for (int k = 0; k < 6; k++) begin
      sweep(0, 0, dc, ns, id);
      chk("int_nspk", 32'(ns), 0);
      chk("int_v3", 32'(dut.v_q[3]), 32'(exp_v[k]));
    end
    sweep(0, 0, dc, ns, id);
    chk("s8_nspk", 32'(ns), 4);
    chk("s8_ids", 32'(id), 32'h3210);
    chk("s8_done_cyc", 32'(dc), 9);
    chk("s8_v2", 32'(dut.v_q[2]), 0);

    // Backpressure on the spiking sweep
    do_reset();
    for (int k = 0; k < 7; k++) sweep(0, 0, dc, ns, id);
    chk("bp_pre_v1", 32'(dut.v_q[1]), 99);
    sweep(5, 0, dc, ns, id);
    chk("bp_nspk", 32'(ns), 4);
    chk("bp_ids", 32'(id), 32'h3210);
    chk("bp_done_cyc", 32'(dc), 14);

    // Refractory
    do_reset();
    refrac_len = 3'd2;
    for (int k = 0; k < 8; k++) sweep(0, 0, dc, ns, id);
    chk("ref_spk_nspk", 32'(ns), 4);
    chk("ref_r0", 32'(dut.r_q[0]), 2);
    sweep(0, 0, dc, ns, id);
    chk("ref1_nspk", 32'(ns), 0);
    chk("ref1_v0", 32'(dut.v_q[0]), 0);
    chk("ref1_done_cyc", 32'(dc), 5);
    sweep(0, 0, dc, ns, id);
    chk("ref2_nspk", 32'(ns), 0);
    chk("ref2_v3", 32'(dut.v_q[3]), 0);
    sweep(0, 0, dc, ns, id);
    chk("ref3_nspk", 32'(ns), 0);
    chk("ref3_v0", 32'(dut.v_q[0]), 20);
    refrac_len = 3'd0;

    // Saturation
    do_reset();
    threshold = 8'd255;
    cur_in    = 8'd250;
    sweep(0, 0, dc, ns, id);
    chk("sat1_nspk", 32'(ns), 0);
    chk("sat1_v2", 32'(dut.v_q[2]), 250);
    sweep(0, 0, dc, ns, id);
    chk("sat2_nspk", 32'(ns), 4);
    chk("sat2_ids", 32'(id), 32'h3210);
    chk("sat2_v0", 32'(dut.v_q[0]), 0);
    threshold = 8'd100;
    cur_in    = 8'd20;

    // Overrun: extra tick at t+2 leaves sweep timing alone
    do_reset();
    chk("ovr_pre", 32'(overrun), 0);
    sweep(0, 2, dc, ns, id);
    chk("ovr_done_cyc", 32'(dc), 5);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_v1", 32'(dut.v_q[1]), 20);
    sweep(0, 0, dc, ns, id);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_v1_next", 32'(dut.v_q[1]), 38);

    // Reset while a spike is pending
    do_reset();
    threshold   = 8'd0;
    spike_ready = 1'b0;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    for (int k = 0; k < 10 && !spike_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("pend_valid", 32'(spike_valid), 1);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    chk("pend_overrun", 32'(overrun), 1);
    chk("pend_hold", 32'(spike_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(spike_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    rst         = 1'b0;
    spike_ready = 1'b1;
    threshold   = 8'd100;
    sweep(0, 0, dc, ns, id);
    chk("post_rst_nspk", 32'(ns), 0);
    chk("post_rst_v0", 32'(dut.v_q[0]), 20);
    chk("post_rst_v3", 32'(dut.v_q[3]), 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
